data_memory_unit: RTL and testbench

- Word-addressed data memory directly downstream of memory_control.
- Consumes address_out, RAM_in and RW, plus a request strobe from the control unit.
- Performs one read or write per request after a programmable number of wait states.
- Returns RAM_out to memory_control's LDR/ADR return path, with a one-cycle ready pulse so the pipeline can stall on busy.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/data_ram_array.sv | 21 ++
 rtl/data_memory_unit.sv | 106 ++++++++++
 tb/tb_data_memory_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU memory path: FSM encoding, opcodes, RW encoding.
package cpu_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT        = 2'd1,
    ACCESS_DONE = 2'd2
  } mem_state_e;

  localparam logic [3:0] ADR = 4'b1100;
  localparam logic [3:0] LDR = 4'b1101;
  localparam logic [3:0] STR = 4'b1110;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // True when no address bit above the array index is set.
  function automatic logic addr_in_range(input logic [31:0] addr, input int addr_w);
    return (addr >> addr_w) == 32'd0;
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Single-port synchronous word RAM with registered read data; contents are not reset.
module data_ram_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_memory_unit.sv
// Word-addressed data memory behind memory_control: one latched access per request
// after WAIT_STATES extra cycles, with a one-cycle mem_ready/addr_err completion pulse.
//
// state       | meaning
// IDLE        | waiting for mem_req; request inputs latched on acceptance
// WAIT        | counting down wait states; array accessed on the edge leaving it
// ACCESS_DONE | mem_ready (and addr_err) valid for this cycle only
module data_memory_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              mem_req,
  input  logic              RW,
  input  logic [31:0]       address_out,
  input  logic [DATA_W-1:0] RAM_in,
  output logic [DATA_W-1:0] RAM_out,
  output logic              mem_busy,
  output logic              mem_ready,
  output logic              addr_err
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  mem_state_e        state;
  logic [3:0]        wait_cnt;
  logic              rw_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              out_zero;
  logic [DATA_W-1:0] rdata;
  logic              access;
  logic              in_range;
  logic              we;
  logic              re;

  assign access   = (state == WAIT) && (wait_cnt == 4'd0);
  assign in_range = addr_in_range(addr_q, ADDR_W);
  assign we       = access && (rw_q == RW_WRITE) && in_range;
  assign re       = access && (rw_q == RW_READ) && in_range;
  assign mem_busy = (state != IDLE);

  // The RAM read register has no reset, so a flag forces RAM_out to zero after
  // reset and after an out-of-range read until the next in-range read lands.
  assign RAM_out  = out_zero ? '0 : rdata;

  data_ram_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .re   (re),
    .idx  (addr_q[ADDR_W-1:0]),
    .wdata(wdata_q),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      rw_q      <= RW_WRITE;
      addr_q    <= 32'd0;
      wdata_q   <= '0;
      out_zero  <= 1'b1;
      mem_ready <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          addr_err  <= 1'b0;
          if (mem_req) begin
            rw_q     <= RW;
            addr_q   <= address_out;
            wdata_q  <= RAM_in;
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            mem_ready <= 1'b1;
            addr_err  <= !in_range;
            if (rw_q == RW_READ) out_zero <= !in_range;
            state <= ACCESS_DONE;
          end
        end
        ACCESS_DONE: begin
          mem_ready <= 1'b0;
          addr_err  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench: three units (WAIT_STATES 1, 3, 0) checked against an array model.
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        Reset;
  logic        req  [3];
  logic        rw   [3];
  logic [31:0] addr [3];
  logic [31:0] din  [3];
  logic [31:0] dout [3];
  logic        busy [3];
  logic        rdy  [3];
  logic        err  [3];

  always #5 clk = ~clk;

  data_memory_unit #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(1)) u0 (
    .clk(clk), .Reset(Reset), .mem_req(req[0]), .RW(rw[0]), .address_out(addr[0]),
    .RAM_in(din[0]), .RAM_out(dout[0]), .mem_busy(busy[0]), .mem_ready(rdy[0]), .addr_err(err[0]));
  data_memory_unit #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(3)) u1 (
    .clk(clk), .Reset(Reset), .mem_req(req[1]), .RW(rw[1]), .address_out(addr[1]),
    .RAM_in(din[1]), .RAM_out(dout[1]), .mem_busy(busy[1]), .mem_ready(rdy[1]), .addr_err(err[1]));
  data_memory_unit #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(0)) u2 (
    .clk(clk), .Reset(Reset), .mem_req(req[2]), .RW(rw[2]), .address_out(addr[2]),
    .RAM_in(din[2]), .RAM_out(dout[2]), .mem_busy(busy[2]), .mem_ready(rdy[2]), .addr_err(err[2]));

  logic [31:0] mem_m   [3][256];
  bit          written [3][256];
  logic [31:0] exp_out [3];
  bit          known   [3];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic int ws_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request on unit i; checks latency, busy, ready, addr_err and RAM_out.
  task automatic access(input int i, input bit is_read, input logic [31:0] a, input logic [31:0] d);
    int   lat;
    bit   oor;
    logic [7:0] ix;
    oor = (a[31:8] != 24'd0);
    ix  = a[7:0];
    @(negedge clk);
    req[i] = 1'b1; rw[i] = is_read; addr[i] = a; din[i] = d;
    @(posedge clk); #1;
    req[i] = 1'b0; rw[i] = 1'($urandom); addr[i] = $urandom; din[i] = $urandom;
    check($sformatf("busy_accept u%0d", i), busy[i], 1'b1);
    if (!is_read && !oor) begin
      mem_m[i][ix]   = d;
      written[i][ix] = 1'b1;
    end
    if (is_read) begin
      if (oor) begin
        exp_out[i] = 32'd0; known[i] = 1'b1;
      end else begin
        exp_out[i] = mem_m[i][ix]; known[i] = written[i][ix];
      end
    end
    lat = 0;
    for (int k = 1; k <= 24 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (rdy[i]) lat = k;
      else check($sformatf("busy_wait u%0d", i), busy[i], 1'b1);
    end
    check($sformatf("ready_latency u%0d a=%h", i, a), lat, ws_of(i) + 1);
    check($sformatf("addr_err u%0d a=%h", i, a), err[i], oor);
    if (known[i]) check($sformatf("ram_out u%0d a=%h rd=%0d", i, a, is_read), dout[i], exp_out[i]);
    @(posedge clk); #1;
    check($sformatf("ready_drop u%0d", i), rdy[i], 1'b0);
    check($sformatf("idle_again u%0d", i), busy[i], 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int per;
    bit exp_b, exp_r;
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; rw[i] = 1'b0; addr[i] = 32'd0; din[i] = 32'd0;
      exp_out[i] = 32'd0; known[i] = 1'b1;
      for (int j = 0; j < 256; j++) written[i][j] = 1'b0;
    end

    Reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); Reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ram_out u%0d", i), dout[i], 32'd0);
      check($sformatf("rst_busy u%0d", i), busy[i], 1'b0);
      check($sformatf("rst_ready u%0d", i), rdy[i], 1'b0);
      check($sformatf("rst_err u%0d", i), err[i], 1'b0);
    end

    // Write then read; RAM_out must stay 0 through the write.
    access(0, 1'b0, 32'h05, 32'hDEADBEEF);
    access(0, 1'b1, 32'h05, 32'h0);

    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 32; j++) access(i, 1'b0, 32'(j), $urandom);

    // mem_req held high: second acceptance only once IDLE is re-entered.
    per = ws_of(0) + 3;
    @(negedge clk);
    req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 32'h10;
    exp_out[0] = mem_m[0][16]; known[0] = 1'b1;
    for (int t = 0; t < 2 * per; t++) begin
      @(posedge clk); #1;
      exp_b = ((t % per) <= ws_of(0) + 1);
      exp_r = ((t % per) == ws_of(0) + 1);
      check($sformatf("hold_busy t=%0d", t), busy[0], exp_b);
      check($sformatf("hold_ready t=%0d", t), rdy[0], exp_r);
      if (t == per) req[0] = 1'b0;
    end
    check("hold_ram_out", dout[0], exp_out[0]);

    // Out-of-range accesses.
    access(0, 1'b0, 32'h00, 32'h0);
    access(0, 1'b0, 32'h100, 32'h12345678);
    access(0, 1'b1, 32'h00, 32'h0);
    check("oor_not_written", 32'(dout[0] != 32'h12345678), 32'd1);
    access(0, 1'b1, 32'h05, 32'h0);
    access(0, 1'b1, 32'h100, 32'h0);

    // Reset during WAIT with two wait states still to go: write must not commit.
    access(1, 1'b0, 32'h07, 32'h0);
    @(negedge clk);
    req[1] = 1'b1; rw[1] = 1'b0; addr[1] = 32'h07; din[1] = 32'hAAAA5555;
    @(posedge clk); #1; req[1] = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin exp_out[i] = 32'd0; known[i] = 1'b1; end
    check("midrst_busy", busy[1], 1'b0);
    check("midrst_ready", rdy[1], 1'b0);
    check("midrst_ram_out", dout[1], 32'd0);
    @(negedge clk); Reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("midrst_no_ready c%0d", k), rdy[1], 1'b0);
    end
    access(1, 1'b1, 32'h07, 32'h0);

    // Zero wait states.
    access(2, 1'b0, 32'h01, 32'h00000042);
    access(2, 1'b1, 32'h01, 32'h0);

    // Randomized traffic against the array model.
    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = a | (32'd1 << $urandom_range(8, 31));
      access(int'($urandom_range(0, 2)), 1'($urandom), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
